ksort_unloader: RTL and testbench
=================================

Name: ksort_unloader

Overview:
- Drains the result of the k-smallest sorting array after a sort pass completes.
- Issues one shift/unload request per entry to the sorter, which returns name/value pairs in ascending order through its output port.
- Buffers the returned pairs in a small FIFO and presents them downstream on a valid/ready stream.
- Stops early when the sorter returns an empty (sentinel) slot, and reports how many entries were delivered.

Parameters:
dataWidth, 32, width of value field (name field fixed at 32)
maxMemory, 1024, sorter depth; upper clamp for k
fifoDepth, 4, output buffer entries (power of 2, >=2)

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  begin an unload pass; sampled only in IDLE
k  input  32  number of entries requested; latched on accepted start
sortShift  output  1  request next entry from sorter; pair returns exactly 1 cycle later
sortNameIn  input  32  name returned by sorter (valid cycle after sortShift)
sortValueIn  input  dataWidth  value returned by sorter (valid cycle after sortShift)
outValid  output  1  downstream entry available
outReady  input  1  downstream accepts entry when outValid&&outReady
outName  output  32  entry name
outValue  output  dataWidth  entry value
busy  output  1  pass in progress (state != IDLE)
done  output  1  one-cycle pulse at end of pass
resultCount  output  32  entries delivered in last pass; stable from done until next accepted start

Behaviour:
- Reset values: sortShift=0, outValid=0, outName=0, outValue=0, busy=0, done=0, resultCount=0. FIFO emptied, state=IDLE.
- States: IDLE, REQ, FLUSH, DONE.
- IDLE, start=1:
  - latch kEff = min(k, maxMemory); clear issued, inflight, stopSeen, resultCount.
  - kEff==0 -> DONE; otherwise -> REQ.
- IDLE, start=0: remain in IDLE.
- start while busy: ignored.
- REQ:
  - sortShift=1 iff issued<kEff && !stopSeen && (fifoCount+inflight)<fifoDepth.
  - inflight is 0 or 1 (the previous cycle's shift).
  - Credit rule guarantees no push into a full FIFO; no return data is ever dropped.
- Return cycle (cycle after sortShift=1):
  - sortNameIn and sortValueIn both all-ones -> sentinel: discard, set stopSeen; no further shifts issued.
  - otherwise -> push pair into FIFO and increment resultCount.
- Returns after stopSeen cannot occur: shifts stop when stopSeen sets, and at most one return is in flight.
- REQ -> FLUSH when (issued==kEff || stopSeen) && inflight==0.
- FLUSH -> DONE when FIFO empty and outValid=0.
- DONE: done=1 for one cycle, then IDLE.
- Output stream:
  - FIFO head drives outName/outValue/outValid combinationally or registered; either way, first-word latency from return cycle to outValid ≤1 cycle.
  - While outValid&&!outReady, outName/outValue must hold stable.
  - Push and pop in the same cycle: count unchanged; order preserved (ascending as returned).
  - Throughput: 1 entry/cycle sustained when outReady=1 continuously.
- Arithmetic: issued and resultCount are 32-bit, no wrap (bounded by maxMemory); fifoCount is log2(fifoDepth)+1 bits.
- Reset mid-pass:
  - next cycle in IDLE, FIFO cleared, outValid=0.
  - a sorter return landing in the cycle after reset is ignored.
- done and start in the same cycle: done completes first; start is accepted on the following IDLE cycle only.

Test Plan:
- Basic pass: sorter model holds values 3,7,9,12,20; k=3; outReady=1. Required: sortShift high 3 times; beats 3,7,9 in order; done pulse; resultCount=3; busy low after done.
- Backpressure: fifoDepth=4, k=8, outReady=0 for 10 cycles then 1. Required: at most 4 shifts before the first pop; all 8 beats delivered ascending; no duplicates or loss; outName/outValue stable while stalled.
- Sentinel stop: sorter holds 2 real entries, remaining slots all-ones; k=5. Required: 3 shifts issued; 2 beats output; resultCount=2; done pulse.
- k=0: start with k=0. Required: no sortShift; done asserted 1 cycle after start; resultCount=0; outValid never high.
- Clamp: k=2000 with maxMemory=1024, sorter full of real entries. Required: exactly 1024 shifts; resultCount=1024.
- Reset mid-pass: k=6; assert reset after the 3rd beat for 1 cycle. Required: outValid=0, busy=0, resultCount=0 next cycle; a new start with k=2 completes normally with 2 beats.

Source files
------------

// File: rtl/ksort_unloader.sv
// ksort_unloader
//
// Drains a k-smallest sorting array after a sort pass. One shift request is
// issued per wanted entry; the sorter answers with a name/value pair exactly
// one cycle later. Returned pairs go through a small FIFO to a valid/ready
// output stream. An all-ones name/value return is a sentinel (empty slot) and
// ends the pass early. The number of delivered entries is reported.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   reset        synchronous active-high reset
//   start        begin a pass (sampled only while idle)
//   k            entries requested, latched with an accepted start
//   sortShift    request the next entry from the sorter
//   sortNameIn   name returned by the sorter (cycle after sortShift)
//   sortValueIn  value returned by the sorter (cycle after sortShift)
//   outValid     output entry available
//   outReady     downstream accepts when outValid && outReady
//   outName      output entry name
//   outValue     output entry value
//   busy         pass in progress
//   done         one-cycle pulse at end of pass
//   resultCount  entries delivered in the last pass
module ksort_unloader #(
  parameter int dataWidth = 32,
  parameter int maxMemory = 1024,
  parameter int fifoDepth = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          k,
  output logic                 sortShift,
  input  logic [31:0]          sortNameIn,
  input  logic [dataWidth-1:0] sortValueIn,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [31:0]          outName,
  output logic [dataWidth-1:0] outValue,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          resultCount
);

  localparam int AW = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam int CW = AW + 1;
  localparam logic [31:0] MAX_K   = 32'(maxMemory);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(fifoDepth);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FLUSH,
    S_DONE
  } state_t;

  function automatic logic [31:0] clamp_k(input logic [31:0] req);
    return (req > MAX_K) ? MAX_K : req;
  endfunction

  function automatic logic is_sentinel(input logic [31:0]          n,
                                       input logic [dataWidth-1:0] v);
    return (&n) && (&v);
  endfunction

  state_t r_state;
  state_t w_next;

  logic [31:0]          r_kEff;
  logic [31:0]          r_issued;
  logic                 r_inflight;
  logic                 r_stopSeen;
  logic [31:0]          r_resultCount;

  logic [31:0]          r_memName  [fifoDepth];
  logic [dataWidth-1:0] r_memValue [fifoDepth];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;

  logic                 w_shift;
  logic                 w_accept;
  logic                 w_retSentinel;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_stop;
  logic                 w_credit;
  logic                 w_outValid;

  // Return stage: r_inflight marks the cycle in which the sorter's answer to
  // the previous cycle's shift is present on sortNameIn/sortValueIn.
  assign w_retSentinel = r_inflight && is_sentinel(sortNameIn, sortValueIn);
  assign w_push        = r_inflight && !is_sentinel(sortNameIn, sortValueIn);

  // A sentinel arriving this cycle must already block this cycle's shift,
  // otherwise one extra request would slip out behind the empty slot.
  assign w_stop   = r_stopSeen || w_retSentinel;

  // Credit: entries held plus the one possibly on its way back must leave
  // room, so a return can always be pushed without checking for full.
  assign w_credit = ({1'b0, r_count} + {{CW{1'b0}}, r_inflight}) < DEPTH_C;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_outValid = (r_count != '0);
  assign w_pop      = w_outValid && outReady;

  always_comb begin
    w_next  = r_state;
    w_shift = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (clamp_k(k) == 32'd0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        w_shift = (r_issued < r_kEff) && !w_stop && w_credit;
        if (((r_issued == r_kEff) || r_stopSeen) && !r_inflight) begin
          w_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (r_count == '0) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request stage: control state, counters and FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_kEff        <= 32'd0;
      r_issued      <= 32'd0;
      r_inflight    <= 1'b0;
      r_stopSeen    <= 1'b0;
      r_resultCount <= 32'd0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_shift;
      if (w_accept) begin
        r_kEff        <= clamp_k(k);
        r_issued      <= 32'd0;
        r_stopSeen    <= 1'b0;
        r_resultCount <= 32'd0;
      end else begin
        if (w_shift) begin
          r_issued <= r_issued + 32'd1;
        end
        if (w_retSentinel) begin
          r_stopSeen <= 1'b1;
        end
        if (w_push) begin
          r_resultCount <= r_resultCount + 32'd1;
        end
      end
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Buffer stage: FIFO storage, data only.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memName[r_wptr]  <= sortNameIn;
      r_memValue[r_wptr] <= sortValueIn;
    end
  end

  assign sortShift   = w_shift;
  assign outValid    = w_outValid;
  assign outName     = w_outValid ? r_memName[r_rptr]  : 32'd0;
  assign outValue    = w_outValid ? r_memValue[r_rptr] : '0;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign resultCount = r_resultCount;

endmodule

// File: tb/tb_ksort_unloader.sv
// Testbench for ksort_unloader: a sorter model answers shift requests from an
// array, a reference model derives the expected beat sequence, shift count and
// result count for each pass, and a monitor checks every output beat.
module tb_ksort_unloader;

  localparam int DW   = 32;
  localparam int MAXM = 1024;
  localparam int FD   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   k;
  logic          sortShift;
  logic [31:0]   sortNameIn  = 32'd0;
  logic [DW-1:0] sortValueIn = '0;
  logic          outValid;
  logic          outReady;
  logic [31:0]   outName;
  logic [DW-1:0] outValue;
  logic          busy;
  logic          done;
  logic [31:0]   resultCount;

  always #5 clk = ~clk;

  ksort_unloader #(.dataWidth(DW), .maxMemory(MAXM), .fifoDepth(FD)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .k          (k),
    .sortShift  (sortShift),
    .sortNameIn (sortNameIn),
    .sortValueIn(sortValueIn),
    .outValid   (outValid),
    .outReady   (outReady),
    .outName    (outName),
    .outValue   (outValue),
    .busy       (busy),
    .done       (done),
    .resultCount(resultCount)
  );

  // Sorter contents, in ascending order as the sorter would present them.
  logic [31:0]   mem_n [MAXM];
  logic [DW-1:0] mem_v [MAXM];
  int            s_ptr = 0;

  // Sorter model: rewinds on an accepted start, answers one cycle after shift.
  always @(posedge clk) begin
    if (start && !busy) s_ptr <= 0;
    else if (sortShift) s_ptr <= s_ptr + 1;
    if (sortShift) begin
      if (s_ptr < MAXM) begin
        sortNameIn  <= mem_n[s_ptr];
        sortValueIn <= mem_v[s_ptr];
      end else begin
        sortNameIn  <= '1;
        sortValueIn <= '1;
      end
    end else begin
      sortNameIn  <= $urandom;
      sortValueIn <= DW'($urandom);
    end
  end

  typedef struct {
    logic [31:0]   n;
    logic [DW-1:0] v;
  } pair_t;

  pair_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on every accepted beat and checks that
  // a stalled beat holds its contents.
  logic          stalled = 1'b0;
  logic [31:0]   held_n;
  logic [DW-1:0] held_v;
  pair_t         mon_p;

  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 64'(outValid), 64'd1);
        chk("stall_name", 64'(outName), 64'(held_n));
        chk("stall_value", 64'(outValue), 64'(held_v));
      end
      if (outValid && outReady) begin
        chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_p = exp_q.pop_front();
          chk("beat_name", 64'(outName), 64'(mon_p.n));
          chk("beat_value", 64'(outValue), 64'(mon_p.v));
        end
      end
      stalled = outValid && !outReady;
      held_n  = outName;
      held_v  = outValue;
    end
  end

  // n_real ascending real entries, every later slot empty (all ones).
  task automatic fill(input int n_real);
    logic [DW-1:0] v;
    v = DW'($urandom_range(0, 50));
    for (int i = 0; i < MAXM; i++) begin
      if (i < n_real) begin
        mem_n[i] = $urandom;
        mem_v[i] = v;
        v = v + DW'($urandom_range(0, 6));
      end else begin
        mem_n[i] = '1;
        mem_v[i] = '1;
      end
    end
  endtask

  // Reference: walk the sorter contents up to min(k, maxMemory) requests,
  // stopping on the first empty slot (which still costs one request).
  task automatic expect_pass(input int kk, output int e_shifts, output int e_count);
    int    keff;
    pair_t p;
    keff     = (kk > MAXM) ? MAXM : kk;
    e_shifts = keff;
    e_count  = 0;
    for (int i = 0; i < keff; i++) begin
      if ((&mem_n[i]) && (&mem_v[i])) begin
        e_shifts = i + 1;
        break;
      end
      p.n = mem_n[i];
      p.v = mem_v[i];
      exp_q.push_back(p);
      e_count++;
    end
  endtask

  // mode 0: ready always; 1: random ready; 2: ready low for 10 cycles
  task automatic run_pass(input int kk, input int mode);
    int es, ec, shifts, cyc, first_pop;
    bit seen;
    expect_pass(kk, es, ec);
    shifts = 0; cyc = 0; first_pop = -1; seen = 0;
    @(posedge clk); #1;
    start = 1'b1;
    k     = 32'(kk);
    @(posedge clk); #1;
    start = 1'b0;
    while (!seen && cyc < 3000) begin
      case (mode)
        0:       outReady = 1'b1;
        1:       outReady = 1'($urandom_range(0, 1));
        default: outReady = (cyc >= 10);
      endcase
      @(negedge clk);
      if (outValid && outReady && first_pop < 0) first_pop = shifts;
      if (sortShift) shifts++;
      if (done) begin
        seen = 1;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("shift_count", 64'(shifts), 64'(es));
    chk("result_count", 64'(resultCount), 64'(ec));
    chk("all_beats_out", 64'(exp_q.size()), 64'd0);
    if (kk == 0) chk("k0_done_latency", 64'(cyc), 64'd0);
    if (mode == 2) chk("bp_shifts_before_pop", 64'(first_pop > 0 && first_pop <= FD), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("count_held", 64'(resultCount), 64'(ec));
  endtask

  task automatic reset_midpass();
    int es, ec, hs, cyc;
    fill(16);
    expect_pass(6, es, ec);
    hs = 0; cyc = 0;
    @(posedge clk); #1;
    start    = 1'b1;
    k        = 32'd6;
    outReady = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (hs < 3 && cyc < 200) begin
      @(negedge clk);
      if (outValid && outReady) hs++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_three_beats", 64'(hs), 64'd3);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_outvalid", 64'(outValid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(resultCount), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_late_return_ignored", 64'(outValid), 64'd0);
    chk("rst_count_late", 64'(resultCount), 64'd0);
    run_pass(2, 0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    k        = 32'd0;
    outReady = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sortShift", 64'(sortShift), 64'd0);
    chk("rst_outValid", 64'(outValid), 64'd0);
    chk("rst_outName", 64'(outName), 64'd0);
    chk("rst_outValue", 64'(outValue), 64'd0);
    chk("rst_busy0", 64'(busy), 64'd0);
    chk("rst_done0", 64'(done), 64'd0);
    chk("rst_resultCount", 64'(resultCount), 64'd0);

    // Basic pass over 3,7,9,12,20 with k=3
    fill(5);
    mem_v[0] = 3; mem_v[1] = 7; mem_v[2] = 9; mem_v[3] = 12; mem_v[4] = 20;
    run_pass(3, 0);

    // Backpressure: ready held low for 10 cycles
    fill(20);
    run_pass(8, 2);

    // Sentinel stop after 2 real entries
    fill(2);
    run_pass(5, 0);

    // k = 0
    fill(10);
    run_pass(0, 0);

    // Clamp to maxMemory
    fill(MAXM);
    run_pass(2000, 0);

    // Reset in the middle of a pass, then a clean pass
    reset_midpass();

    // Random passes with random ready
    for (int t = 0; t < 10; t++) begin
      fill($urandom_range(0, 12));
      run_pass($urandom_range(0, 15), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
